npu_sequencer: RTL and testbench

NPU_SEQUENCER -- requirements
Module: npu_sequencer

---
 rtl/npu_seq_pkg.sv | 20 ++
 rtl/seq_event_counter.sv | 31 +++
 rtl/npu_sequencer.sv | 143 ++++++++++++++
 tb/tb_npu_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_seq_pkg.sv
// Shared types and defaults for the NPU frame sequencer.
package npu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCompute,
    StTx,
    StDone
  } seq_state_e;

  localparam int unsigned DefInBytes  = 65536;
  localparam int unsigned DefNpuWords = 8192;
  localparam int unsigned DefOutBytes = 65536;

  localparam int unsigned RxCntW  = 17;
  localparam int unsigned NpuCntW = 14;
  localparam int unsigned TxCntW  = 17;

endpackage

// File: rtl/seq_event_counter.sv
// Event counter that saturates at MAX; at_max flags the increment that lands on MAX.
module seq_event_counter #(
  parameter int unsigned MAX   = 8,
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] LastVal = WIDTH'(MAX - 1);
  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX);

  // Combinational so the owner can leave its state on the same edge the count completes.
  assign at_max = inc && !clr && (count == LastVal);

  // Count events; clear wins, and the value never moves past MAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MaxVal)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/npu_sequencer.sv
// Frame sequencer: UART bytes into input memory, NPU beats into output memory,
// then output bytes back out over UART, one frame at a time.
module npu_sequencer
  import npu_seq_pkg::*;
#(
  parameter int unsigned IN_BYTES  = DefInBytes,
  parameter int unsigned NPU_WORDS = DefNpuWords,
  parameter int unsigned OUT_BYTES = DefOutBytes
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic        npu_done,
  input  logic        tx_done,
  input  logic        soft_clr,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic        npu_en,
  output logic        out_we,
  output logic [12:0] out_addr,
  output logic        tx_en,
  output logic [1:0]  tx_lane,
  output logic        tx_hi,
  output logic        busy,
  output logic        frame_done,
  output logic        rx_overrun
);

  localparam int unsigned LogOut = $clog2(OUT_BYTES);
  // Byte index layout in TX: [0] half select, [LogOut-3:1] word, [LogOut-1:LogOut-2] lane.
  localparam logic [TxCntW-1:0] TxAddrMask = TxCntW'(OUT_BYTES / 8 - 1);

  seq_state_e           state_q;
  logic                 overrun_q;
  logic [RxCntW-1:0]    rx_cnt;
  logic [NpuCntW-1:0]   npu_cnt;
  logic [TxCntW-1:0]    tx_cnt;
  logic                 rx_max, npu_max, tx_max;
  logic                 rx_inc, npu_inc, tx_inc, cnt_clr;
  logic                 live;
  logic                 unused_rx_msb;

  assign unused_rx_msb = rx_cnt[RxCntW-1];

  // Strobes are suppressed during reset and on an abort cycle.
  assign live    = rst & ~soft_clr;
  assign rx_inc  = rx_done & ((state_q == StIdle) | (state_q == StLoad));
  assign npu_inc = npu_done & (state_q == StCompute);
  assign tx_inc  = tx_done & (state_q == StTx);
  assign cnt_clr = soft_clr | (state_q == StDone);

  seq_event_counter #(.MAX(IN_BYTES), .WIDTH(RxCntW)) u_rx_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (rx_inc),
    .clr    (cnt_clr),
    .count  (rx_cnt),
    .at_max (rx_max)
  );

  seq_event_counter #(.MAX(NPU_WORDS), .WIDTH(NpuCntW)) u_npu_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (npu_inc),
    .clr    (cnt_clr),
    .count  (npu_cnt),
    .at_max (npu_max)
  );

  seq_event_counter #(.MAX(OUT_BYTES), .WIDTH(TxCntW)) u_tx_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (tx_inc),
    .clr    (cnt_clr),
    .count  (tx_cnt),
    .at_max (tx_max)
  );

  // Frame FSM plus the sticky overrun flag; an abort overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      overrun_q <= 1'b0;
    end else if (soft_clr) begin
      state_q   <= StIdle;
      overrun_q <= 1'b0;
    end else begin
      if (rx_done && (state_q inside {StCompute, StTx, StDone})) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle:    if (rx_done) state_q <= rx_max ? StCompute : StLoad;
        StLoad:    if (rx_max) state_q <= StCompute;
        StCompute: if (npu_max) state_q <= StTx;
        StTx:      if (tx_max) state_q <= StDone;
        StDone:    state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Output decode from the current state and counter of that state.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = '0;
    npu_en     = 1'b0;
    out_we     = 1'b0;
    out_addr   = '0;
    tx_en      = 1'b0;
    tx_lane    = '0;
    tx_hi      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_we = rx_done & live;
      end
      StLoad: begin
        mem_we   = rx_done & live;
        mem_addr = rx_cnt[15:0];
      end
      StCompute: begin
        npu_en   = 1'b1;
        mem_addr = 16'({npu_cnt, 1'b0});
        out_we   = npu_done & live;
        out_addr = npu_cnt[12:0];
      end
      StTx: begin
        tx_en    = 1'b1;
        tx_hi    = tx_cnt[0];
        out_addr = 13'((tx_cnt >> 1) & TxAddrMask);
        tx_lane  = 2'(tx_cnt >> (LogOut - 2));
      end
      StDone: begin
        frame_done = ~soft_clr;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_npu_sequencer.sv
// Self-checking bench for npu_sequencer with a small frame configuration.
module tb_npu_sequencer;

  localparam int IB = 8;
  localparam int NW = 2;
  localparam int OB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_done = 1'b0, npu_done = 1'b0, tx_done = 1'b0, soft_clr = 1'b0;
  logic        mem_we, npu_en, out_we, tx_en, tx_hi, busy, frame_done, rx_overrun;
  logic [15:0] mem_addr;
  logic [12:0] out_addr;
  logic [1:0]  tx_lane;

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;
  // Reference model: bytes/beats consumed in the current frame and the overrun flag.
  int m_r = 0, m_n = 0, m_t = 0, m_ovr = 0;

  typedef struct {
    int rx, npu, tx, sc;
    int we, ma, ne, ow, oa, te, tl, th, bz, fd;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  npu_sequencer #(.IN_BYTES(IB), .NPU_WORDS(NW), .OUT_BYTES(OB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .npu_done   (npu_done),
    .tx_done    (tx_done),
    .soft_clr   (soft_clr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .npu_en     (npu_en),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .tx_en      (tx_en),
    .tx_lane    (tx_lane),
    .tx_hi      (tx_hi),
    .busy       (busy),
    .frame_done (frame_done),
    .rx_overrun (rx_overrun)
  );

  function automatic logic [38:0] pack(int we, int ma, int ne, int ow, int oa, int te, int tl,
                                       int th, int bz, int fd, int ov);
    return {1'(we), 16'(ma), 1'(ne), 1'(ow), 13'(oa), 1'(te), 2'(tl), 1'(th), 1'(bz), 1'(fd),
            1'(ov)};
  endfunction

  function automatic logic [38:0] dut_vec();
    return {mem_we, mem_addr, npu_en, out_we, out_addr, tx_en, tx_lane, tx_hi, busy, frame_done,
            rx_overrun};
  endfunction

  task automatic check(input string name, input logic [38:0] got, input logic [38:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Which phase of the frame the model is in, from how much of it has been consumed.
  function automatic int phase();
    if (m_t >= OB) return 4;
    if (m_r == 0) return 0;
    if (m_r < IB) return 1;
    if (m_n < NW) return 2;
    return 3;
  endfunction

  function automatic logic [38:0] model_exp(int rx, int npu, int sc);
    int ph = phase();
    int lv = (sc == 0) ? 1 : 0;
    case (ph)
      0: return pack(rx & lv, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_ovr);
      1: return pack(rx & lv, m_r, 0, 0, 0, 0, 0, 0, 1, 0, m_ovr);
      2: return pack(0, 2 * m_n, 1, npu & lv, m_n, 0, 0, 0, 1, 0, m_ovr);
      3: return pack(0, 0, 0, 0, (m_t / 2) % (OB / 8), 1, m_t / (OB / 4), m_t % 2, 1, 0, m_ovr);
      default: return pack(0, 0, 0, 0, 0, 0, 0, 0, 1, lv, m_ovr);
    endcase
  endfunction

  task automatic model_update(input int rx, input int npu, input int tx, input int sc);
    int ph = phase();
    if (sc != 0) begin
      m_r = 0; m_n = 0; m_t = 0; m_ovr = 0;
    end else begin
      if (rx != 0 && ph >= 2) m_ovr = 1;
      case (ph)
        0, 1: if (rx != 0) m_r++;
        2:    if (npu != 0) m_n++;
        3:    if (tx != 0) m_t++;
        default: begin m_r = 0; m_n = 0; m_t = 0; end
      endcase
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model.
  task automatic step(input string name, input int rx, input int npu, input int tx, input int sc);
    rx_done = 1'(rx); npu_done = 1'(npu); tx_done = 1'(tx); soft_clr = 1'(sc);
    #4;
    check(name, dut_vec(), model_exp(rx, npu, sc));
    if (frame_done) fd_seen++;
    model_update(rx, npu, tx, sc);
    @(posedge clk); #1;
    rx_done = 1'b0; npu_done = 1'b0; tx_done = 1'b0; soft_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("reset_outputs", dut_vec(), '0);
    m_r = 0; m_n = 0; m_t = 0; m_ovr = 0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_frame(input string name);
    for (int i = 0; i < IB; i++) step({name, "_load"}, 1, 0, 0, 0);
    for (int i = 0; i < NW; i++) step({name, "_npu"}, 0, 1, 0, 0);
    for (int i = 0; i < OB; i++) step({name, "_tx"}, 0, 0, 1, 0);
    step({name, "_done"}, 0, 0, 0, 0);
    step({name, "_idle"}, 0, 0, 0, 0);
  endtask

  task automatic add(input int rx, input int npu, input int tx, input int we, input int ma,
                     input int ne, input int ow, input int oa, input int te, input int tl,
                     input int th, input int bz, input int fd);
    vec_t v;
    v = '{rx, npu, tx, 0, we, ma, ne, ow, oa, te, tl, th, bz, fd};
    tbl.push_back(v);
  endtask

  initial begin
    int fd0;
    // Directed frame: inputs and the outputs they must produce in the same cycle.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < IB; k++) begin
      add(1, 0, 0, 1, k, 0, 0, 0, 0, 0, 0, 1, 0);
      if (k == 3) add(0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 2, 1, 1, 1, 0, 0, 0, 1, 0);
    for (int t = 0; t < OB; t++) begin
      if (t == 4) add(0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, t / 2, t % 2, 1, 0);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    #1;
    do_reset();
    foreach (tbl[i]) begin
      rx_done = 1'(tbl[i].rx); npu_done = 1'(tbl[i].npu); tx_done = 1'(tbl[i].tx);
      soft_clr = 1'(tbl[i].sc);
      #4;
      check($sformatf("tbl[%0d]", i), dut_vec(),
            pack(tbl[i].we, tbl[i].ma, tbl[i].ne, tbl[i].ow, tbl[i].oa, tbl[i].te, tbl[i].tl,
                 tbl[i].th, tbl[i].bz, tbl[i].fd, 0));
      @(posedge clk); #1;
      rx_done = 1'b0; npu_done = 1'b0; tx_done = 1'b0; soft_clr = 1'b0;
    end

    // Overrun: byte arrives during COMPUTE, then an abort clears the flag.
    do_reset();
    for (int i = 0; i < IB; i++) step("ovr_load", 1, 0, 0, 0);
    step("ovr_rx_in_compute", 1, 0, 0, 0);
    check("ovr_set", {38'b0, rx_overrun}, 39'd1);
    step("ovr_npu0", 0, 1, 0, 0);
    step("ovr_npu1", 0, 1, 0, 0);
    step("ovr_tx0", 0, 0, 1, 0);
    step("ovr_abort", 0, 0, 0, 1);
    check("ovr_cleared", {37'b0, rx_overrun, busy}, 39'd0);

    // Abort on the terminal NPU beat of the second frame.
    do_reset();
    run_frame("f1");
    for (int i = 0; i < IB; i++) step("f2_load", 1, 0, 0, 0);
    step("f2_npu3", 0, 1, 0, 0);
    fd0 = fd_seen;
    step("f2_npu4_abort", 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step("f2_after_abort", 0, 0, 0, 0);
    check("abort_no_frame_done", 39'(fd_seen - fd0), 39'd0);

    // Asynchronous reset in the middle of TX, then a clean frame.
    do_reset();
    for (int i = 0; i < IB; i++) step("rtx_load", 1, 0, 0, 0);
    for (int i = 0; i < NW; i++) step("rtx_npu", 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("rtx_tx", 0, 0, 1, 0);
    rst = 1'b0; rx_done = 1'b1; tx_done = 1'b1;
    #1;
    check("reset_mid_tx", dut_vec(), '0);
    rx_done = 1'b0; tx_done = 1'b0;
    m_r = 0; m_n = 0; m_t = 0; m_ovr = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    fd0 = fd_seen;
    run_frame("post_reset");
    check("post_reset_one_frame_done", 39'(fd_seen - fd0), 39'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
